// File: rtl/hazard_detect_unit_pkg.sv
// Shared constants, stall-reason encoding and helpers for the decode-stage hazard detector.
package riscv_hazard_pkg;

    localparam int unsigned NREG   = 32;
    localparam int unsigned REG_AW = 5;

    typedef enum logic [1:0] {
        NONE      = 2'd0,
        LOAD_USE  = 2'd1,
        LOAD_FULL = 2'd2,
        MEM_BUSY  = 2'd3
    } stall_reason_e;

    function automatic logic is_x0(input logic [REG_AW-1:0] idx);
        return idx == '0;
    endfunction

endpackage

// File: rtl/hazard_detect_unit_if.sv
// ID/WB-side signal bundle between the pipeline and the hazard detector.
interface hazard_detect_unit_if #(
    parameter int unsigned NREG   = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 2
);
    import riscv_hazard_pkg::*;

    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic              id_is_load;
    logic [REG_AW-1:0] id_rd;
    logic              stall;
    logic              flush;
    logic              wb_load_done;
    logic [REG_AW-1:0] wb_rd;
    logic              mem_busy;
    logic              stall_req;
    logic [NREG-1:0]   pend_map;
    logic [CNT_W-1:0]  load_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_is_load, id_rd,
        output stall, flush, wb_load_done, wb_rd, mem_busy,
        input  stall_req, pend_map, load_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_is_load, id_rd,
        input  stall, flush, wb_load_done, wb_rd, mem_busy,
        output stall_req, pend_map, load_cnt
    );

endinterface

// File: rtl/hazard_detect_unit_load_scoreboard.sv
// Pending-load register bitmap and in-flight counter with set/clear/kill arbitration.
module load_scoreboard #(
    parameter int unsigned NREG      = 32,
    parameter int unsigned REG_AW    = 5,
    parameter int unsigned MAX_LOADS = 2,
    parameter int unsigned CNT_W     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [REG_AW-1:0] set_idx,
    input  logic              clr_en,
    input  logic [REG_AW-1:0] clr_idx,
    input  logic              kill_en,
    input  logic [REG_AW-1:0] kill_idx,
    input  logic [REG_AW-1:0] rd_idx_a,
    input  logic [REG_AW-1:0] rd_idx_b,
    output logic              pend_a,
    output logic              pend_b,
    output logic [NREG-1:0]   pend_map,
    output logic [CNT_W-1:0]  load_cnt
);
    import riscv_hazard_pkg::*;

    logic [NREG-1:0] map_next;
    logic [CNT_W:0]  cnt_next;

    function automatic logic is_pending(input logic [REG_AW-1:0] idx);
        return pend_map[idx];
    endfunction

    assign pend_a = is_pending(rd_idx_a);
    assign pend_b = is_pending(rd_idx_b);

    // Clears are applied before the set so a same-cycle reissue keeps the bit pending.
    always_comb begin
        map_next = pend_map;
        if (clr_en)
            map_next[clr_idx] = 1'b0;
        if (kill_en)
            map_next[kill_idx] = 1'b0;
        if (set_en && !is_x0(set_idx))
            map_next[set_idx] = 1'b1;
        map_next[0] = 1'b0;
    end

    always_comb begin
        cnt_next = {1'b0, load_cnt}
                 + {{CNT_W{1'b0}}, set_en}
                 - {{CNT_W{1'b0}}, clr_en}
                 - {{CNT_W{1'b0}}, kill_en};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_map <= '0;
            load_cnt <= '0;
        end else begin
            pend_map <= map_next;
            load_cnt <= cnt_next[CNT_W-1:0];
        end
    end

    // An underflow wraps into the extra bit, so one bound covers both directions.
    a_cnt_range: assert property (@(posedge clk) disable iff (rst)
        cnt_next <= (CNT_W+1)'(MAX_LOADS));

endmodule

// File: rtl/hazard_detect_unit.sv
// Decode-stage load-use hazard detector; define HAZARD_STATS_EN to add stall statistics outputs.
module hazard_detect_unit #(
    parameter int unsigned NREG      = riscv_hazard_pkg::NREG,
    parameter int unsigned REG_AW    = riscv_hazard_pkg::REG_AW,
    parameter int unsigned MAX_LOADS = 2,
    parameter int unsigned CNT_W     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_detect_unit_if.slave  hif
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]          stall_cycles,
    output logic [15:0]          load_use_cnt
`endif
);
    import riscv_hazard_pkg::*;

    logic              id_fire;
    logic              set_ev;
    logic              clr_ev;
    logic              kill_ev;
    logic              ex_load_v;
    logic [REG_AW-1:0] ex_load_rd;
    logic              pend_rs1;
    logic              pend_rs2;
    logic              hazard_rs1;
    logic              hazard_rs2;
    logic              load_full;

    assign id_fire = hif.id_valid & ~hif.stall & ~hif.flush;
    assign set_ev  = id_fire & hif.id_is_load & ~is_x0(hif.id_rd);
    assign clr_ev  = hif.wb_load_done & ~is_x0(hif.wb_rd);
    assign kill_ev = hif.flush & ex_load_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_load_v  <= 1'b0;
            ex_load_rd <= '0;
        end else begin
            ex_load_v <= set_ev;
            if (set_ev)
                ex_load_rd <= hif.id_rd;
        end
    end

    load_scoreboard #(
        .NREG      (NREG),
        .REG_AW    (REG_AW),
        .MAX_LOADS (MAX_LOADS),
        .CNT_W     (CNT_W)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (set_ev),
        .set_idx  (hif.id_rd),
        .clr_en   (clr_ev),
        .clr_idx  (hif.wb_rd),
        .kill_en  (kill_ev),
        .kill_idx (ex_load_rd),
        .rd_idx_a (hif.id_rs1),
        .rd_idx_b (hif.id_rs2),
        .pend_a   (pend_rs1),
        .pend_b   (pend_rs2),
        .pend_map (hif.pend_map),
        .load_cnt (hif.load_cnt)
    );

    // A register being written back this cycle is readable through the register file.
    assign hazard_rs1 = pend_rs1 & hif.id_rs1_used & ~is_x0(hif.id_rs1)
                      & ~(hif.wb_load_done & (hif.wb_rd == hif.id_rs1));
    assign hazard_rs2 = pend_rs2 & hif.id_rs2_used & ~is_x0(hif.id_rs2)
                      & ~(hif.wb_load_done & (hif.wb_rd == hif.id_rs2));
    assign load_full  = hif.id_is_load & (hif.load_cnt == CNT_W'(MAX_LOADS));

    assign hif.stall_req = ~rst & hif.id_valid & ~hif.flush
                         & (hazard_rs1 | hazard_rs2 | load_full | hif.mem_busy);

`ifdef HAZARD_STATS_EN
    stall_reason_e reason;

    always_comb begin
        reason = NONE;
        if (hif.stall_req) begin
            if (hazard_rs1 | hazard_rs2)
                reason = LOAD_USE;
            else if (load_full)
                reason = LOAD_FULL;
            else
                reason = MEM_BUSY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            load_use_cnt <= '0;
        end else begin
            if (hif.stall_req && stall_cycles != '1)
                stall_cycles <= stall_cycles + 32'd1;
            if (reason == LOAD_USE && load_use_cnt != '1)
                load_use_cnt <= load_use_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_detect_unit.sv
// Directed self-checking bench for hazard_detect_unit (optionally with HAZARD_STATS_EN).
module tb_hazard_detect_unit;

    logic clk;
    logic rst;
    int unsigned checks;
    int unsigned errors;

    hazard_detect_unit_if #(.NREG(32), .REG_AW(5), .CNT_W(2)) hif ();

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles;
    logic [15:0] load_use_cnt;
`endif

    hazard_detect_unit #(
        .NREG      (32),
        .REG_AW    (5),
        .MAX_LOADS (2),
        .CNT_W     (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .hif          (hif)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cycles (stall_cycles),
        .load_use_cnt (load_use_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        hif.id_valid     = 1'b0;
        hif.id_rs1       = '0;
        hif.id_rs2       = '0;
        hif.id_rs1_used  = 1'b0;
        hif.id_rs2_used  = 1'b0;
        hif.id_is_load   = 1'b0;
        hif.id_rd        = '0;
        hif.stall        = 1'b0;
        hif.flush        = 1'b0;
        hif.wb_load_done = 1'b0;
        hif.wb_rd        = '0;
        hif.mem_busy     = 1'b0;
    endtask

    task automatic load(input logic [4:0] rd);
        idle();
        hif.id_valid   = 1'b1;
        hif.id_is_load = 1'b1;
        hif.id_rd      = rd;
    endtask

    task automatic use_rs(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2);
        idle();
        hif.id_valid    = 1'b1;
        hif.id_rs1      = rs1;
        hif.id_rs1_used = u1;
        hif.id_rs2      = rs2;
        hif.id_rs2_used = u2;
    endtask

    task automatic wb(input logic [4:0] rd);
        idle();
        hif.wb_load_done = 1'b1;
        hif.wb_rd        = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle();
        rst = 1'b1;
        hif.id_valid = 1'b1;
        hif.mem_busy = 1'b1;
        settle();
        check("rst_stall_req", 32'(hif.stall_req), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        idle();
        settle();
        check("rst_pend_map", hif.pend_map, 32'h0);
        check("rst_load_cnt", 32'(hif.load_cnt), 32'd0);

        // load x5 then a dependent read, bypass on writeback
        load(5'd5); settle();
        check("ld5_no_stall", 32'(hif.stall_req), 32'd0);
        tick();
        use_rs(5'd5, 1'b1, 5'd0, 1'b0); hif.stall = 1'b1; settle();
        check("use5_stall", 32'(hif.stall_req), 32'd1);
        check("use5_map", hif.pend_map, 32'h0000_0020);
        check("use5_cnt", 32'(hif.load_cnt), 32'd1);
        tick();
        use_rs(5'd5, 1'b1, 5'd0, 1'b0); hif.stall = 1'b1; settle();
        check("use5_stall2", 32'(hif.stall_req), 32'd1);
        tick();
        use_rs(5'd5, 1'b1, 5'd0, 1'b0); hif.wb_load_done = 1'b1; hif.wb_rd = 5'd5; settle();
        check("use5_bypass", 32'(hif.stall_req), 32'd0);
        tick();
        idle(); settle();
        check("wb5_map", hif.pend_map, 32'h0);
        check("wb5_cnt", 32'(hif.load_cnt), 32'd0);

        // load to x0 is ignored
        load(5'd0); tick();
        use_rs(5'd0, 1'b1, 5'd0, 1'b1); settle();
        check("x0_map", hif.pend_map, 32'h0);
        check("x0_cnt", 32'(hif.load_cnt), 32'd0);
        check("x0_stall", 32'(hif.stall_req), 32'd0);
        tick();

        // capacity limit
        load(5'd1); tick();
        load(5'd2); settle();
        check("ld2_no_stall", 32'(hif.stall_req), 32'd0);
        tick();
        load(5'd3); hif.stall = 1'b1; settle();
        check("full_map", hif.pend_map, 32'h0000_0006);
        check("full_cnt", 32'(hif.load_cnt), 32'd2);
        check("full_stall", 32'(hif.stall_req), 32'd1);
        tick();
        load(5'd3); hif.stall = 1'b1; hif.wb_load_done = 1'b1; hif.wb_rd = 5'd1; tick();
        load(5'd3); settle();
        check("freed_cnt", 32'(hif.load_cnt), 32'd1);
        check("freed_stall", 32'(hif.stall_req), 32'd0);
        tick();
        idle(); settle();
        check("ld3_map", hif.pend_map, 32'h0000_000C);
        check("ld3_cnt", 32'(hif.load_cnt), 32'd2);
        wb(5'd2); tick();
        wb(5'd3); tick();
        idle(); settle();
        check("drain_cnt", 32'(hif.load_cnt), 32'd0);

        // flush kills load in EX
        load(5'd7); tick();
        use_rs(5'd7, 1'b1, 5'd0, 1'b0); hif.flush = 1'b1; settle();
        check("flush_stall", 32'(hif.stall_req), 32'd0);
        tick();
        use_rs(5'd7, 1'b1, 5'd0, 1'b0); settle();
        check("flush_map", hif.pend_map, 32'h0);
        check("flush_cnt", 32'(hif.load_cnt), 32'd0);
        check("flush_read7", 32'(hif.stall_req), 32'd0);
        tick();

        // same-cycle clear and set of x3
        load(5'd3); tick();
        load(5'd3); hif.wb_load_done = 1'b1; hif.wb_rd = 5'd3; tick();
        idle(); settle();
        check("setclr_map", hif.pend_map, 32'h0000_0008);
        check("setclr_cnt", 32'(hif.load_cnt), 32'd1);
        wb(5'd3); tick();

        // rs2 hazard, rs_used gating, mem_busy
        load(5'd9); tick();
        use_rs(5'd0, 1'b0, 5'd9, 1'b1); settle();
        check("rs2_stall", 32'(hif.stall_req), 32'd1);
        use_rs(5'd0, 1'b0, 5'd9, 1'b0); hif.stall = 1'b1; settle();
        check("rs2_unused", 32'(hif.stall_req), 32'd0);
        use_rs(5'd0, 1'b0, 5'd0, 1'b0); hif.stall = 1'b1; hif.mem_busy = 1'b1; settle();
        check("mem_busy", 32'(hif.stall_req), 32'd1);
        tick();
        wb(5'd9); tick();

        // reset mid-operation
        load(5'd2); tick();
        load(5'd5); tick();
        idle(); settle();
        check("pre_rst_map", hif.pend_map, 32'h0000_0024);
        check("pre_rst_cnt", 32'(hif.load_cnt), 32'd2);
        load(5'd6); rst = 1'b1; settle();
        check("mid_rst_stall", 32'(hif.stall_req), 32'd0);
        tick();
        rst = 1'b0;
        use_rs(5'd5, 1'b1, 5'd2, 1'b1); settle();
        check("post_rst_map", hif.pend_map, 32'h0);
        check("post_rst_cnt", 32'(hif.load_cnt), 32'd0);
        check("post_rst_stall", 32'(hif.stall_req), 32'd0);

`ifdef HAZARD_STATS_EN
        check("stats_rst", stall_cycles, 32'd0);
        check("lu_rst", 32'(load_use_cnt), 32'd0);
        use_rs(5'd0, 1'b0, 5'd0, 1'b0); hif.mem_busy = 1'b1; hif.stall = 1'b1;
        tick(); tick(); tick();
        idle(); settle();
        check("stats_busy3", stall_cycles, 32'd3);
        check("lu_busy3", 32'(load_use_cnt), 32'd0);
        load(5'd4); tick();
        use_rs(5'd4, 1'b1, 5'd0, 1'b0); hif.stall = 1'b1; tick();
        idle(); settle();
        check("stats_lu", stall_cycles, 32'd4);
        check("lu_one", 32'(load_use_cnt), 32'd1);
        wb(5'd4); tick();
`endif

        idle();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_detect_unit.md
Name: hazard_detect_unit

Overview:
- Decode-stage hazard detector for the 5-stage RV32I pipeline.
- Tracks in-flight load destinations in a register scoreboard and raises stall_req toward stall_control when the instruction in ID reads a register that is not yet written back.
- Also raises stall_req when the load-tracking capacity is full or data memory is busy.
- Holds ID-stage state only; stall sequencing beyond stall_req is downstream.

Parameters:
- NREG, 32, number of architectural registers; x0 is hard-wired zero.
- REG_AW, 5, register index width; must equal clog2(NREG).
- MAX_LOADS, 2, maximum loads allowed in flight between ID issue and writeback.
- CNT_W, 2, width of the in-flight counter; must be at least clog2(MAX_LOADS+1).

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  valid instruction in ID.
- id_rs1  in  REG_AW  source register 1 index.
- id_rs2  in  REG_AW  source register 2 index.
- id_rs1_used  in  1  instruction reads rs1.
- id_rs2_used  in  1  instruction reads rs2.
- id_is_load  in  1  instruction is a load.
- id_rd  in  REG_AW  destination register index.
- stall  in  1  global stall, fed back from the stall controller.
- flush  in  1  squash ID and EX this cycle (branch/jump redirect).
- wb_load_done  in  1  a load writes the register file this cycle.
- wb_rd  in  REG_AW  destination of that load.
- mem_busy  in  1  data memory is not ready to accept a request.
- stall_req  out  1  stall request to the stall controller (combinational).
- pend_map  out  NREG  scoreboard bitmap (registered).
- load_cnt  out  CNT_W  loads in flight (registered).

Behaviour:
- id_fire = id_valid & ~stall & ~flush. The instruction leaves ID only on id_fire.
- Reset, on a clk edge with rst=1:
  - pend_map=0, load_cnt=0, ex_load_v=0, ex_load_rd=0.
  - stall_req is forced to 0 while rst=1.
- Set event: id_fire & id_is_load & id_rd!=0.
  - Sets pend_map[id_rd].
  - Registers ex_load_v=1 and ex_load_rd=id_rd for one cycle (tracks the load now in EX).
- Clear event: wb_load_done & wb_rd!=0.
  - Clears pend_map[wb_rd].
- ex_load_v update: ex_load_v is 0 after any cycle without a set event.
- Flush: if flush & ex_load_v, clear pend_map[ex_load_rd] and decrement load_cnt, because that load is squashed.
- load_cnt next value is load_cnt + set - clear - flush_kill.
  - Each term is 0 or 1.
  - All three may coincide; the result never underflows or exceeds MAX_LOADS (assertion).
- Same register set and cleared in one cycle: the set wins, so the bit stays 1.
- Same register killed by flush and set by a new issue: the set wins.
- Hazard on a source: pend_map[rs] & rs_used & rs!=0 & ~(wb_load_done & wb_rd==rs).
  - The last term covers WB-to-ID bypass through the register file.
- stall_req = id_valid & ~flush & (hazard_rs1 | hazard_rs2 | (id_is_load & load_cnt==MAX_LOADS) | mem_busy).
- Latency:
  - Scoreboard updates are visible on the next cycle.
  - stall_req reacts within the same cycle.
- Per-register FSM, tracked implicitly in the bitmap:
  - FREE → PENDING on a set event.
  - PENDING → FREE on a clear or flush-kill.
  - PENDING → PENDING on a set plus clear in the same cycle.
- x0 is never marked pending.
- Writes to index 0 are ignored.
- A reset mid-operation discards all in-flight tracking; the pipeline is flushed by the same reset.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined:
  - Adds output stall_cycles, 32 bits.
  - It is a saturating count of cycles with stall_req=1, cleared by rst.
  - Adds output load_use_cnt, 16 bits, saturating, counting cycles where hazard_rs1|hazard_rs2 caused the stall.
- When undefined: neither port nor counter exists, and behaviour is otherwise identical.

Decomposition:
- Package riscv_hazard_pkg:
  - REG_AW and NREG constants.
  - A stall-reason enum: NONE, LOAD_USE, LOAD_FULL, MEM_BUSY.
  - Helper function is_x0(idx).
- One sub-module, load_scoreboard:
  - Contains pend_map, load_cnt, and set/clear/kill arbitration.
  - Exposes a combinational is_pending(idx) for two read ports.
- hazard_detect_unit keeps the ex_load tracking, the stall_req logic and the optional stats.

Test Plan:
- Load x5 issues; the next instruction reads rs1=x5 → stall_req=1 until the cycle wb_load_done with wb_rd=5, where stall_req=0 (bypass) and pend_map[5]=0 on the following cycle.
- Load to x0; then read x0 → pend_map stays 0, load_cnt stays 0, stall_req=0.
- With MAX_LOADS=2, issue loads to x1 and x2 with no writeback; a third load in ID → stall_req=1. A wb_load_done for x1 → load_cnt=1 and the third load fires.
- Load x7 issues, then flush on the next cycle → pend_map[7]=0, load_cnt back to 0, and no stall on a later read of x7.
- Same-cycle wb_load_done for x3 and new load fire to x3 → pend_map[3]=1, load_cnt unchanged.
- Assert rst with pend_map=0x24 and load_cnt=2 → next cycle all zero, stall_req=0. With HAZARD_STATS_EN, stall_cycles resets to 0 and increments once per stalled cycle.
